// File: rtl/draw_command_sequencer.sv
// draw_command_sequencer: per-frame timed draw-command sequencer (clk_i/rst_i async high; frame_tick_i, note_enable_i, digit_enable_i in; command_o, busy_o, frame_done_o, overrun_o out)
module draw_command_sequencer #(
  parameter int CLEAR_CYCLES = 3240,
  parameter int NOTE_CYCLES  = 16,
  parameter int LINE_CYCLES  = 16,
  parameter int DIGIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        frame_tick_i,
  input  logic [14:0] note_enable_i,
  input  logic        digit_enable_i,
  output logic [4:0]  command_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        overrun_o
);
  localparam logic [4:0] NOP    = 5'b10110;
  localparam logic [4:0] CLEAR  = 5'b10100;
  localparam logic [4:0] LINE_L = 5'b10111;
  localparam logic [4:0] LINE_R = 5'b11000;
  localparam logic [4:0] LINE_M = 5'b11001;
  localparam logic [4:0] DIG1   = 5'b10001;
  localparam logic [4:0] DIG2   = 5'b10010;
  localparam logic [4:0] COMMIT = 5'b10101;
  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_NOTES, S_LINE_L, S_LINE_R, S_LINE_M, S_DIG1, S_DIG2, S_COMMIT
  } state_e;
  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [11:0] cnt_q, cnt_d, lim;
  logic [14:0] notes_q, notes_d;
  logic        dig_q, dig_d, last;
  logic [4:0]  cmd_q, cmd_d;
  logic        busy_q, done_q, ovr_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 12'd1;
    notes_d = notes_q;
    dig_d   = dig_q;
    lim = (state_q == S_CLEAR) ? 12'(CLEAR_CYCLES) :
          (state_q == S_NOTES) ? (notes_q[idx_q] ? 12'(NOTE_CYCLES) : 12'd1) :
          (state_q inside {S_LINE_L, S_LINE_R, S_LINE_M}) ? 12'(LINE_CYCLES) :
          (state_q inside {S_DIG1, S_DIG2}) ? 12'(DIGIT_CYCLES) : 12'd1;
    last = cnt_q == lim - 12'd1;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (frame_tick_i) begin
        state_d = S_CLEAR;
        notes_d = note_enable_i;
        dig_d   = digit_enable_i;
      end
    end else if (last) begin
      cnt_d = '0;
      case (state_q)
        S_CLEAR:  begin state_d = S_NOTES; idx_d = '0; end
        S_NOTES:  if (idx_q == 4'd14) begin state_d = S_LINE_L; idx_d = '0; end else idx_d = idx_q + 4'd1;
        S_LINE_L: state_d = S_LINE_R;
        S_LINE_R: state_d = S_LINE_M;
        S_LINE_M: state_d = dig_q ? S_DIG1 : S_COMMIT;
        S_DIG1:   state_d = S_DIG2;
        S_DIG2:   state_d = S_COMMIT;
        default:  state_d = S_IDLE;
      endcase
    end
    // command is registered from the next state so it lines up with the state it names
    case (state_d)
      S_CLEAR:  cmd_d = CLEAR;
      S_NOTES:  cmd_d = notes_d[idx_d] ? 5'd2 + {1'b0, idx_d} : NOP;
      S_LINE_L: cmd_d = LINE_L;
      S_LINE_R: cmd_d = LINE_R;
      S_LINE_M: cmd_d = LINE_M;
      S_DIG1:   cmd_d = DIG1;
      S_DIG2:   cmd_d = DIG2;
      S_COMMIT: cmd_d = COMMIT;
      default:  cmd_d = NOP;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      notes_q <= '0;
      dig_q   <= 1'b0;
      cmd_q   <= NOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      notes_q <= notes_d;
      dig_q   <= dig_d;
      cmd_q   <= cmd_d;
      busy_q  <= state_d != S_IDLE;
      done_q  <= state_q == S_COMMIT;
      ovr_q   <= frame_tick_i && state_q != S_IDLE;
    end
  end
  assign command_o    = cmd_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign overrun_o    = ovr_q;
endmodule
